// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) and divide (restoring on magnitudes).
// Handles the multi-cycle ALU ops; the 64-bit result feeds the Z register pair.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LAST = CW'(WIDTH-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   q_q;
  logic               qm1_q;
  logic [WIDTH-1:0]   m_q;
  logic               op_div_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     acc_sum;
  logic [WIDTH:0]     acc_mul_d;
  logic [WIDTH-1:0]   q_mul_d;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_div_d;
  logic [WIDTH-1:0]   q_div_d;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg(v) : v;
  endfunction

  // Per-iteration datapath for Booth step, restoring-divide step and sign fixup.
  always_comb begin
    m_ext = {m_q[WIDTH-1], m_q};
    case ({q_q[0], qm1_q})
      2'b10:   acc_sum = acc_q - m_ext;
      2'b01:   acc_sum = acc_q + m_ext;
      default: acc_sum = acc_q;
    endcase
    acc_mul_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_mul_d   = {acc_sum[0], q_q[WIDTH-1:1]};

    // The shifted partial remainder can need one bit more than WIDTH.
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});
    if (div_ge) begin
      rem_div_d = div_shift[WIDTH-1:0] - m_q;
    end else begin
      rem_div_d = div_shift[WIDTH-1:0];
    end
    q_div_d = {q_q[WIDTH-2:0], div_ge};

    quot_fix = (sign_a_q ^ sign_b_q) ? neg(q_q) : q_q;
    rem_fix  = sign_a_q ? neg(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      op_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_div_q <= op_div;
            sign_a_q <= A[WIDTH-1];
            sign_b_q <= B[WIDTH-1];
            dbz_q    <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            if (!op_div) begin
              m_q     <= A;
              q_q     <= B;
              state_q <= S_MUL;
            end else if (B != '0) begin
              m_q     <= abs_val(B);
              q_q     <= abs_val(A);
              state_q <= S_DIV;
            end else begin
              // Raw dividend is parked in q_q for the divide-by-zero result.
              m_q     <= '0;
              q_q     <= A;
              state_q <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_mul_d;
          q_q   <= q_mul_d;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_FIXUP;
          end
        end
        S_DIV: begin
          acc_q <= {1'b0, rem_div_d};
          q_q   <= q_div_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (op_div_q) begin
            result_q <= {rem_fix, quot_fix};
          end else begin
            result_q <= {acc_q[WIDTH-1:0], q_q};
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (op_div_q && (m_q == '0)) begin
            result_q <= {q_q, ONES};
            dbz_q    <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
